// File: rtl/serial_subtractor_if.sv
// Bit-serial subtractor handshake bundle: start strobe and operands in,
// busy/done status and registered difference/borrow out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Ports: clk, reset (async high), bus.start/a/b in, bus.busy/done/diff/borrow_out out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bout;

  assign w_x    = r_a_sh[0];
  assign w_y    = r_b_sh[0];
  assign w_d    = w_x ^ w_y ^ r_borrow;
  assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_bout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state  <= S_SHIFT;
            r_busy   <= 1'b1;
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_d_sh   <= {w_d, r_d_sh[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // last bit: publish the full word in one step
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_diff  <= {w_d, r_d_sh[WIDTH-1:1]};
            r_bout  <= w_bout;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor: latency, results,
// back-to-back relaunch, reset abort.
module tb_serial_subtractor;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(8)) u_if ();

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Launch one op; returns samples from start edge to done (-1 if none)
  // and the number of busy samples seen. rnd scrambles inputs mid-op.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                       input bit rnd, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.a     = ta;
    u_if.b     = tb_;
    @(negedge clk);
    u_if.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (u_if.busy) bc++;
      if (u_if.done) begin
        lat = k;
        u_if.start = 1'b0;
        break;
      end
      if (rnd) begin
        u_if.a     = 8'($urandom);
        u_if.b     = 8'($urandom);
        u_if.start = (k <= 7) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int dcnt;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] full;
    total = 0;
    bad   = 0;
    u_if.start = 1'b0;
    u_if.a     = '0;
    u_if.b     = '0;
    reset      = 1'b1;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
    vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[5] = '{8'd128, 8'd1,   8'd127, 1'b0};
    vecs[6] = '{8'd1,   8'd2,   8'd255, 1'b1};
    vecs[7] = '{8'd200, 8'd100, 8'd100, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_done", 32'(u_if.done), 0);
    chk("rst_diff", 32'(u_if.diff), 0);
    chk("rst_bo",   32'(u_if.borrow_out), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, lat, bc);
      chk($sformatf("v%0d_lat", i),  32'(lat), 8);
      chk($sformatf("v%0d_busy", i), 32'(bc), 8);
      chk($sformatf("v%0d_diff", i), 32'(u_if.diff), 32'(vecs[i].d));
      chk($sformatf("v%0d_bo", i),   32'(u_if.borrow_out), 32'(vecs[i].bo));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(u_if.done), 0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_hold", i), 32'(u_if.diff), 32'(vecs[i].d));
    end

    // start held through SHIFT, then relaunch straight out of DONE
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.a     = 8'd20;
    u_if.b     = 8'd4;
    @(negedge clk);
    u_if.a = 8'd9;
    u_if.b = 8'd3;
    lat  = -1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (u_if.done) begin
        dcnt++;
        if (dcnt == 1) begin
          chk("b2b_lat1", 32'(k), 8);
          chk("b2b_diff1", 32'(u_if.diff), 16);
          lat = k;
        end else begin
          chk("b2b_gap", 32'(k - lat), 9);
          chk("b2b_diff2", 32'(u_if.diff), 6);
          chk("b2b_bo2", 32'(u_if.borrow_out), 0);
          break;
        end
      end
      if (dcnt == 1 && k > lat) u_if.start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_count", 32'(dcnt), 2);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-operation aborts
    u_if.start = 1'b1;
    u_if.a     = 8'd50;
    u_if.b     = 8'd1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", 32'(u_if.busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(u_if.busy), 0);
    chk("abort_diff", 32'(u_if.diff), 0);
    chk("abort_bo",   32'(u_if.borrow_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcnt  = 0;
    for (int k = 0; k < 12; k++) begin
      if (u_if.done) dcnt++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(dcnt), 0);
    do_op(8'd7, 8'd2, 1'b0, lat, bc);
    chk("post_rst_lat",  32'(lat), 8);
    chk("post_rst_diff", 32'(u_if.diff), 5);

    // random ops with inputs scrambled while shifting
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      full = {1'b0, ra} - {1'b0, rb};
      do_op(ra, rb, 1'b1, lat, bc);
      chk($sformatf("r%0d_res", n), {22'd0, 1'(lat == 8), 1'(ra < rb), u_if.diff},
          {22'd0, 1'b1, full[8], full[7:0]});
      @(negedge clk);
      chk($sformatf("r%0d_once", n), 32'(u_if.done), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
